// File: rtl/rrat_freelist.sv
// rrat_freelist: retirement RAT plus a circular physical-register free list.
// Dispatch takes pdests from spec_head. Retirement consumes the slot at
// ret_head and refills it with the pdest that the new mapping supersedes.
// A branch miss rewinds spec_head to the retirement point, which returns
// every in-flight pdest in one cycle.
module rrat_freelist #(
    parameter int PRF_SZ  = 64,
    parameter int PRF_IDX = 6,
    parameter int ARF_SZ  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alloc1_req,
    input  logic                        alloc2_req,
    output logic                        alloc1_gnt,
    output logic                        alloc2_gnt,
    output logic [PRF_IDX-1:0]          alloc_pdest1,
    output logic [PRF_IDX-1:0]          alloc_pdest2,
    input  logic                        ret1_valid,
    input  logic                        ret2_valid,
    input  logic [$clog2(ARF_SZ)-1:0]   ret_adest1,
    input  logic [$clog2(ARF_SZ)-1:0]   ret_adest2,
    input  logic [PRF_IDX-1:0]          ret_pdest1,
    input  logic [PRF_IDX-1:0]          ret_pdest2,
    input  logic                        branch_miss,
    output logic [$clog2(PRF_SZ-ARF_SZ):0] free_cnt,
    output logic [ARF_SZ*PRF_IDX-1:0]   rrat_map
);

    localparam int FL_SZ   = PRF_SZ - ARF_SZ;
    localparam int FL_IDX  = $clog2(FL_SZ);
    localparam int ARF_IDX = $clog2(ARF_SZ);
    localparam logic [ARF_IDX-1:0] ZERO_REG = ARF_IDX'(ARF_SZ - 1);
    localparam logic [FL_IDX:0]    FL_FULL  = (FL_IDX+1)'(FL_SZ);

    logic [PRF_IDX-1:0] fl   [FL_SZ];
    logic [PRF_IDX-1:0] rrat [ARF_SZ];
    logic [FL_IDX-1:0]  spec_head;
    logic [FL_IDX-1:0]  ret_head;
    logic [FL_IDX:0]    inflight;

    logic               ret1_do;
    logic               ret2_do;
    logic [PRF_IDX-1:0] freed1;
    logic [PRF_IDX-1:0] freed2;
    logic [FL_IDX-1:0]  spec_head_p1;
    logic [FL_IDX-1:0]  wr_idx2;
    logic [FL_IDX-1:0]  ret_head_next;
    logic [FL_IDX:0]    n_gnt;
    logic [FL_IDX:0]    n_ret;
    logic [FL_IDX:0]    inflight_next;

    // Grants look only at the registered count, so a slot freed by retirement
    // this cycle is not allocatable until the next one.
    assign alloc1_gnt   = !reset && !branch_miss && alloc1_req && (free_cnt != '0);
    assign alloc2_gnt   = alloc2_req && alloc1_gnt && (free_cnt >= (FL_IDX+1)'(2));
    assign spec_head_p1 = spec_head + FL_IDX'(1);
    assign alloc_pdest1 = fl[spec_head];
    assign alloc_pdest2 = fl[spec_head_p1];

    // The zero register is never renamed, so its retirements are ignored.
    assign ret1_do = ret1_valid && (ret_adest1 != ZERO_REG);
    assign ret2_do = ret2_valid && (ret_adest2 != ZERO_REG);

    // Work out the superseded pdests, the second write slot and the next pointer values.
    always_comb begin
        freed1        = rrat[ret_adest1];
        freed2        = rrat[ret_adest2];
        wr_idx2       = ret_head;
        n_gnt         = '0;
        n_ret         = '0;
        if (ret1_do && (ret_adest2 == ret_adest1)) begin
            freed2 = ret_pdest1;
        end
        if (ret1_do) begin
            wr_idx2 = ret_head + FL_IDX'(1);
        end
        n_gnt         = (FL_IDX+1)'(alloc1_gnt) + (FL_IDX+1)'(alloc2_gnt);
        n_ret         = (FL_IDX+1)'(ret1_do) + (FL_IDX+1)'(ret2_do);
        ret_head_next = ret_head + n_ret[FL_IDX-1:0];
        inflight_next = inflight + n_gnt - n_ret;
    end

    // Commit the retiring mappings and recycle the superseded pdests into the free list.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ARF_SZ; i++) begin
                rrat[i] <= PRF_IDX'(i);
            end
            for (int k = 0; k < FL_SZ; k++) begin
                fl[k] <= PRF_IDX'(ARF_SZ + k);
            end
        end else begin
            if (ret1_do) begin
                fl[ret_head]     <= freed1;
                rrat[ret_adest1] <= ret_pdest1;
            end
            if (ret2_do) begin
                fl[wr_idx2]      <= freed2;
                rrat[ret_adest2] <= ret_pdest2;
            end
        end
    end

    // Advance the head pointers and counters; a branch miss rewinds speculation.
    always_ff @(posedge clk) begin
        if (reset) begin
            spec_head <= '0;
            ret_head  <= '0;
            inflight  <= '0;
            free_cnt  <= FL_FULL;
        end else begin
            ret_head <= ret_head_next;
            if (branch_miss) begin
                spec_head <= ret_head_next;
                inflight  <= '0;
                free_cnt  <= FL_FULL;
            end else begin
                spec_head <= spec_head + n_gnt[FL_IDX-1:0];
                inflight  <= inflight_next;
                free_cnt  <= FL_FULL - inflight_next;
            end
        end
    end

    // Flatten the committed map for the front-end RAT restore path.
    always_comb begin
        rrat_map = '0;
        for (int i = 0; i < ARF_SZ; i++) begin
            rrat_map[i*PRF_IDX +: PRF_IDX] = rrat[i];
        end
    end

endmodule
